evm_ballot_ctrl: RTL and testbench

EVM_BALLOT_CTRL -- requirements
Module: evm_ballot_ctrl

---
 rtl/evm_pkg.sv | 40 ++++
 rtl/evm_btn_sync.sv | 27 ++
 rtl/evm_ballot_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_evm_ballot_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared definitions for the EVM ballot controller: FSM states, candidate
// codes, voting-unit readout selects and the default count width.
package evm_pkg;

  localparam int EVM_WIDTH = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_VOTE,
    ST_CAST,
    ST_CLOSE,
    ST_RD_C1,
    ST_RD_C2,
    ST_RD_C3,
    ST_RD_WIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] CAND_NONE = 2'b00;
  localparam logic [1:0] CAND_C1   = 2'b01;
  localparam logic [1:0] CAND_C2   = 2'b10;
  localparam logic [1:0] CAND_C3   = 2'b11;

  localparam logic [1:0] SEL_C1    = 2'b00;
  localparam logic [1:0] SEL_C2    = 2'b01;
  localparam logic [1:0] SEL_C3    = 2'b10;
  localparam logic [1:0] SEL_NONE  = 2'b11;

  // Simultaneous presses of several voter buttons map to CAND_NONE.
  function automatic logic [1:0] cand_code(input logic [2:0] v);
    case (v)
      3'b001:  return CAND_C1;
      3'b010:  return CAND_C2;
      3'b100:  return CAND_C3;
      default: return CAND_NONE;
    endcase
  endfunction

endpackage

// File: rtl/evm_btn_sync.sv
// Two-flop synchronizer plus rising-edge detector for one raw push button.
module evm_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Presiding-officer ballot controller: issues ballots, forwards single votes,
// closes the session and captures the voting unit's results.
module evm_ballot_ctrl
  import evm_pkg::*;
#(
  parameter int WIDTH = EVM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_issue,
  input  logic             btn_close,
  input  logic [2:0]       btn_vote,
  input  logic             evm_voting_in_progress,
  input  logic             evm_voting_done,
  input  logic             evm_invalid_results,
  input  logic [1:0]       evm_candidate_name,
  input  logic [WIDTH-1:0] evm_results,
  output logic             candidate_ready,
  output logic             vote_candidate_1,
  output logic             vote_candidate_2,
  output logic             vote_candidate_3,
  output logic             voting_session_done,
  output logic [1:0]       display_results,
  output logic             display_winner,
  output logic [WIDTH-1:0] tally_1,
  output logic [WIDTH-1:0] tally_2,
  output logic [WIDTH-1:0] tally_3,
  output logic [1:0]       winner_name,
  output logic [WIDTH-1:0] winner_votes,
  output logic             result_invalid,
  output logic             tally_valid,
  output logic [WIDTH-1:0] ballots_issued,
  output logic             ballot_abandoned
);

  logic       w_issue_edge;
  logic       w_close_edge;
  logic [2:0] w_vote_edge;
  logic       w_rd_abort;

  state_t     r_state;
  logic       r_first;
  logic       r_idle_seen;

  evm_btn_sync u_sync_issue (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_issue),
    .o_rise (w_issue_edge)
  );

  evm_btn_sync u_sync_close (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_close),
    .o_rise (w_close_edge)
  );

  for (genvar g = 0; g < 3; g++) begin : g_vote_sync
    evm_btn_sync u_sync_vote (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (btn_vote[g]),
      .o_rise (w_vote_edge[g])
    );
  end

  // Losing evm_voting_done mid-readout means the results are no longer valid.
  assign w_rd_abort = (r_state inside {ST_RD_C1, ST_RD_C2, ST_RD_C3, ST_RD_WIN})
                      && !evm_voting_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state             <= ST_IDLE;
      r_first             <= 1'b0;
      r_idle_seen         <= 1'b0;
      candidate_ready     <= 1'b0;
      vote_candidate_1    <= 1'b0;
      vote_candidate_2    <= 1'b0;
      vote_candidate_3    <= 1'b0;
      voting_session_done <= 1'b0;
      display_results     <= SEL_NONE;
      display_winner      <= 1'b0;
      tally_1             <= '0;
      tally_2             <= '0;
      tally_3             <= '0;
      winner_name         <= CAND_NONE;
      winner_votes        <= '0;
      result_invalid      <= 1'b0;
      tally_valid         <= 1'b0;
      ballots_issued      <= '0;
      ballot_abandoned    <= 1'b0;
    end else begin
      candidate_ready  <= 1'b0;
      vote_candidate_1 <= 1'b0;
      vote_candidate_2 <= 1'b0;
      vote_candidate_3 <= 1'b0;
      ballot_abandoned <= 1'b0;

      if (w_rd_abort) begin
        r_state         <= ST_IDLE;
        display_results <= SEL_NONE;
        display_winner  <= 1'b0;
        tally_valid     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (evm_voting_done) begin
              r_state         <= ST_RD_C1;
              display_results <= SEL_C1;
            end else if (w_issue_edge) begin
              r_state         <= ST_ISSUE;
              candidate_ready <= 1'b1;
              if (ballots_issued != '1) ballots_issued <= ballots_issued + 1'b1;
            end else if (w_close_edge) begin
              r_state             <= ST_CLOSE;
              voting_session_done <= 1'b1;
            end
          end

          ST_ISSUE: begin
            r_state     <= ST_WAIT_VOTE;
            r_first     <= 1'b1;
            r_idle_seen <= 1'b0;
          end

          // The first cycle here is ignored for abandonment: the voting unit
          // needs a cycle to react to candidate_ready.
          ST_WAIT_VOTE: begin
            r_first <= 1'b0;
            if (evm_voting_in_progress) begin
              r_idle_seen <= 1'b0;
              case (cand_code(w_vote_edge))
                CAND_C1: begin
                  vote_candidate_1 <= 1'b1;
                  r_state          <= ST_CAST;
                end
                CAND_C2: begin
                  vote_candidate_2 <= 1'b1;
                  r_state          <= ST_CAST;
                end
                CAND_C3: begin
                  vote_candidate_3 <= 1'b1;
                  r_state          <= ST_CAST;
                end
                default: ;
              endcase
            end else if (!r_first) begin
              if (r_idle_seen) begin
                ballot_abandoned <= 1'b1;
                r_state          <= ST_IDLE;
              end else begin
                r_idle_seen <= 1'b1;
              end
            end
          end

          ST_CAST: r_state <= ST_IDLE;

          ST_CLOSE: begin
            if (evm_voting_done) begin
              voting_session_done <= 1'b0;
              display_results     <= SEL_C1;
              r_state             <= ST_RD_C1;
            end
          end

          // Each select is presented for one cycle and captured on exit.
          ST_RD_C1: begin
            tally_1         <= evm_results;
            result_invalid  <= evm_invalid_results;
            display_results <= SEL_C2;
            r_state         <= ST_RD_C2;
          end

          ST_RD_C2: begin
            tally_2         <= evm_results;
            display_results <= SEL_C3;
            r_state         <= ST_RD_C3;
          end

          ST_RD_C3: begin
            tally_3         <= evm_results;
            display_results <= SEL_NONE;
            display_winner  <= 1'b1;
            r_state         <= ST_RD_WIN;
          end

          ST_RD_WIN: begin
            winner_name    <= evm_candidate_name;
            winner_votes   <= evm_results;
            display_winner <= 1'b0;
            tally_valid    <= 1'b1;
            r_state        <= ST_DONE;
          end

          ST_DONE: begin
            if (!evm_voting_done) begin
              tally_valid <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Scoreboard bench for evm_ballot_ctrl with a behavioural voting-unit model.
module tb_evm_ballot_ctrl;

  localparam int W    = 7;
  localparam int MAXV = (1 << W) - 1;

  localparam int EV_READY   = 0;
  localparam int EV_VOTE    = 1;
  localparam int EV_ABANDON = 2;
  localparam int EV_TALLY   = 3;

  typedef struct {
    int kind;
    int v;
    int t1;
    int t2;
    int t3;
    int wn;
    int wv;
    int inv;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         btn_issue;
  logic         btn_close;
  logic [2:0]   btn_vote;
  logic         evm_voting_in_progress = 1'b0;
  logic         evm_voting_done;
  logic         evm_invalid_results;
  logic [1:0]   evm_candidate_name;
  logic [W-1:0] evm_results;
  logic         candidate_ready;
  logic         vote_candidate_1;
  logic         vote_candidate_2;
  logic         vote_candidate_3;
  logic         voting_session_done;
  logic [1:0]   display_results;
  logic         display_winner;
  logic [W-1:0] tally_1;
  logic [W-1:0] tally_2;
  logic [W-1:0] tally_3;
  logic [1:0]   winner_name;
  logic [W-1:0] winner_votes;
  logic         result_invalid;
  logic         tally_valid;
  logic [W-1:0] ballots_issued;
  logic         ballot_abandoned;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ready_cyc = 0;
  bit   prev_tv = 1'b0;
  exp_t q[$];
  exp_t last_tally;
  int   exp_issued = 0;
  int   exp_cnt [3];
  int   session_id = 0;
  bit   env_resp = 1'b1;

  int         env_sid = 0;
  int         env_c [3] = '{0, 0, 0};
  logic [1:0] env_w;

  evm_ballot_ctrl #(.WIDTH(W)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .btn_issue              (btn_issue),
    .btn_close              (btn_close),
    .btn_vote               (btn_vote),
    .evm_voting_in_progress (evm_voting_in_progress),
    .evm_voting_done        (evm_voting_done),
    .evm_invalid_results    (evm_invalid_results),
    .evm_candidate_name     (evm_candidate_name),
    .evm_results            (evm_results),
    .candidate_ready        (candidate_ready),
    .vote_candidate_1       (vote_candidate_1),
    .vote_candidate_2       (vote_candidate_2),
    .vote_candidate_3       (vote_candidate_3),
    .voting_session_done    (voting_session_done),
    .display_results        (display_results),
    .display_winner         (display_winner),
    .tally_1                (tally_1),
    .tally_2                (tally_2),
    .tally_3                (tally_3),
    .winner_name            (winner_name),
    .winner_votes           (winner_votes),
    .result_invalid         (result_invalid),
    .tally_valid            (tally_valid),
    .ballots_issued         (ballots_issued),
    .ballot_abandoned       (ballot_abandoned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Voting unit model: arms on a ballot, counts one vote per pulse.
  always @(negedge clk) begin
    if (env_sid != session_id) begin
      env_sid                <= session_id;
      env_c                  <= '{0, 0, 0};
      evm_voting_in_progress <= 1'b0;
    end else begin
      if (candidate_ready && env_resp) evm_voting_in_progress <= 1'b1;
      if (vote_candidate_1) begin env_c[0] <= env_c[0] + 1; evm_voting_in_progress <= 1'b0; end
      if (vote_candidate_2) begin env_c[1] <= env_c[1] + 1; evm_voting_in_progress <= 1'b0; end
      if (vote_candidate_3) begin env_c[2] <= env_c[2] + 1; evm_voting_in_progress <= 1'b0; end
    end
  end

  function automatic logic [1:0] win_code(input int a, input int b, input int c);
    if (a > b && a > c) return 2'b01;
    if (b > a && b > c) return 2'b10;
    if (c > a && c > b) return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    env_w               = win_code(env_c[0], env_c[1], env_c[2]);
    evm_invalid_results = (env_w == 2'b00);
    evm_candidate_name  = 2'b00;
    evm_results         = '0;
    if (env_w != 2'b00) begin
      if (display_winner) begin
        evm_candidate_name = env_w;
        case (env_w)
          2'b01:   evm_results = W'(env_c[0]);
          2'b10:   evm_results = W'(env_c[1]);
          default: evm_results = W'(env_c[2]);
        endcase
      end else begin
        case (display_results)
          2'b00:   evm_results = W'(env_c[0]);
          2'b01:   evm_results = W'(env_c[1]);
          2'b10:   evm_results = W'(env_c[2]);
          default: evm_results = '0;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int v);
    exp_t e;
    e = '{kind: kind, v: v, t1: 0, t2: 0, t3: 0, wn: 0, wv: 0, inv: 0};
    q.push_back(e);
  endtask

  // Expected readout: a unique maximum wins, otherwise everything reads zero.
  task automatic push_tally();
    exp_t e;
    int   m;
    int   n;
    int   idx;
    m = 0; n = 0; idx = 0;
    foreach (exp_cnt[i]) if (exp_cnt[i] > m) m = exp_cnt[i];
    foreach (exp_cnt[i]) if (exp_cnt[i] == m) begin n++; idx = i; end
    e = '{kind: EV_TALLY, v: 0, t1: 0, t2: 0, t3: 0, wn: 0, wv: 0, inv: 1};
    if (n == 1) begin
      e.t1 = exp_cnt[0]; e.t2 = exp_cnt[1]; e.t3 = exp_cnt[2];
      e.wn = idx + 1; e.wv = m; e.inv = 0;
    end
    last_tally = e;
    q.push_back(e);
  endtask

  task automatic observe(input int kind, input int v);
    exp_t e;
    check($sformatf("sb_has_entry_kind%0d", kind), q.size() > 0, 1);
    if (q.size() == 0) return;
    e = q.pop_front();
    check("event_kind", kind, e.kind);
    if (kind != e.kind) return;
    if (kind == EV_TALLY) begin
      check("tally_1", tally_1, e.t1);
      check("tally_2", tally_2, e.t2);
      check("tally_3", tally_3, e.t3);
      check("winner_name", winner_name, e.wn);
      check("winner_votes", winner_votes, e.wv);
      check("result_invalid", result_invalid, e.inv);
    end else begin
      check($sformatf("event%0d_value", kind), v, e.v);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin tick(); n++; end
    check("sb_drain", q.size(), 0);
    q.delete();
  endtask

  task automatic wait_vip(input bit val, input int budget);
    int n;
    n = 0;
    while (evm_voting_in_progress !== val && n < budget) begin tick(); n++; end
    check("vip_wait", evm_voting_in_progress, val);
  endtask

  task automatic expect_ready();
    exp_issued = (exp_issued >= MAXV) ? MAXV : exp_issued + 1;
    push_ev(EV_READY, exp_issued);
  endtask

  task automatic press_issue();
    btn_issue = 1'b1; tick(2); btn_issue = 1'b0;
  endtask

  task automatic cast_vote(input int cand, input logic [2:0] dbl);
    expect_ready();
    press_issue();
    wait_vip(1'b1, 20);
    if (dbl != 3'b000) begin
      btn_vote = dbl; tick(2); btn_vote = 3'b000; tick(4);
    end
    push_ev(EV_VOTE, cand);
    exp_cnt[cand-1]++;
    btn_vote = 3'(1 << (cand - 1)); tick(2); btn_vote = 3'b000;
    wait_vip(1'b0, 20);
    wait_drain(10);
    tick(2);
  endtask

  // Ballot issued to an unresponsive voting unit: abandoned 4 cycles after
  // candidate_ready (1 ISSUE cycle + 3 WAIT_VOTE cycles).
  task automatic abandon_ballot(input bit late_vote);
    env_resp = 1'b0;
    expect_ready();
    push_ev(EV_ABANDON, 4);
    press_issue();
    if (late_vote) begin
      btn_vote = 3'b001; tick(2); btn_vote = 3'b000;
    end
    wait_drain(20);
    tick(3);
    env_resp = 1'b1;
  endtask

  task automatic new_session();
    exp_cnt = '{0, 0, 0};
    session_id++;
    tick(2);
  endtask

  task automatic do_close();
    int n;
    btn_close = 1'b1; tick(2); btn_close = 1'b0;
    n = 0;
    while (voting_session_done !== 1'b1 && n < 10) begin tick(); n++; end
    check("vsd_asserted", voting_session_done, 1);
    tick($urandom_range(1, 4));
    check("vsd_held", voting_session_done, 1);
    push_tally();
    evm_voting_done = 1'b1;
    wait_drain(20);
    check("vsd_released", voting_session_done, 0);
    check("done_display_results", display_results, 2'b11);
    check("done_display_winner", display_winner, 0);
    check("done_tally_valid", tally_valid, 1);
    press_issue();
    tick(4);
    evm_voting_done = 1'b0;
    tick(3);
    check("tally_valid_cleared", tally_valid, 0);
    check("tally_retained", {tally_1, tally_2, tally_3},
          {W'(last_tally.t1), W'(last_tally.t2), W'(last_tally.t3)});
    new_session();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pulses_flags"}, {candidate_ready, vote_candidate_1, vote_candidate_2,
          vote_candidate_3, ballot_abandoned, voting_session_done, display_winner,
          tally_valid, result_invalid}, 0);
    check({tag, "_display_results"}, display_results, 2'b11);
    check({tag, "_tallies"}, {tally_1, tally_2, tally_3}, 0);
    check({tag, "_winner"}, {winner_name, winner_votes}, 0);
    check({tag, "_ballots_issued"}, ballots_issued, 0);
  endtask

  task automatic shuffled_session(input int n1, input int n2, input int n3);
    int order[$];
    int j;
    int t;
    repeat (n1) order.push_back(1);
    repeat (n2) order.push_back(2);
    repeat (n3) order.push_back(3);
    for (int i = order.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    foreach (order[i]) cast_vote(order[i], 3'b000);
    do_close();
  endtask

  initial begin
    logic [2:0] pats [4];
    bit         found;
    pats = '{3'b011, 3'b101, 3'b110, 3'b111};
    exp_cnt = '{0, 0, 0};
    rst = 1'b0;
    btn_issue = 1'b0; btn_close = 1'b0; btn_vote = 3'b000;
    evm_voting_done = 1'b0;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          cyc++;
          if (!rst) begin
            prev_tv = 1'b0;
          end else begin
            if (candidate_ready) begin
              ready_cyc = cyc;
              observe(EV_READY, int'(ballots_issued));
            end
            if (vote_candidate_1 || vote_candidate_2 || vote_candidate_3) begin
              check("vote_onehot", $countones({vote_candidate_1, vote_candidate_2, vote_candidate_3}), 1);
              check("vote_without_ready", candidate_ready, 0);
              observe(EV_VOTE, vote_candidate_1 ? 1 : (vote_candidate_2 ? 2 : 3));
            end
            if (ballot_abandoned) observe(EV_ABANDON, cyc - ready_cyc);
            if (tally_valid && !prev_tv) observe(EV_TALLY, 0);
            prev_tv = tally_valid;
          end
        end
      end
      begin : stim
        tick(3);
        check_reset_vals("por");
        rst = 1'b1;
        tick(2);

        cast_vote(1, 3'b000);
        cast_vote(3, 3'b011);
        abandon_ballot(1'b1);
        do_close();

        shuffled_session(5, 3, 2);
        shuffled_session(4, 4, 1);

        // Voting unit closes on its own, then drops done mid-readout.
        evm_voting_done = 1'b1; tick(2);
        evm_voting_done = 1'b0; tick(8);
        check("abort_tally_valid", tally_valid, 0);
        check("abort_display", {display_results, display_winner}, 3'b110);
        new_session();

        for (int s = 0; s < 4; s++) begin
          for (int b = $urandom_range(0, 5); b > 0; b--) begin
            if ($urandom_range(0, 9) < 2) abandon_ballot(1'b0);
            else cast_vote($urandom_range(1, 3),
                           ($urandom_range(0, 3) == 0) ? pats[$urandom_range(0, 3)] : 3'b000);
          end
          do_close();
        end

        while (exp_issued < MAXV) abandon_ballot(1'b0);
        abandon_ballot(1'b0);
        abandon_ballot(1'b0);
        check("ballots_saturated", ballots_issued, MAXV);

        // Reset while the vote pulse is on the wire.
        expect_ready();
        press_issue();
        wait_vip(1'b1, 20);
        btn_vote = 3'b010;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
          tick();
          if (i == 1) btn_vote = 3'b000;
          if (vote_candidate_1 || vote_candidate_2 || vote_candidate_3) found = 1'b1;
        end
        check("cast_reached", found, 1);
        rst = 1'b0;
        exp_issued = 0;
        exp_cnt = '{0, 0, 0};
        session_id++;
        tick(2);
        check_reset_vals("midop");
        wait_drain(2);
        rst = 1'b1;
        tick(3);

        cast_vote(2, 3'b000);
        do_close();
        wait_drain(5);
      end
    join_any

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
